// File: rtl/alu_sequencer.sv
// alu_sequencer: queues ALU operation requests in a small FIFO, issues them to
// the ALU one at a time, waits a fixed latency for the accumulator-registered
// result and returns it over a valid/ready response channel.
// Optional feature macro: ALU_SEQ_CHAIN_EN (adds req_chain, which substitutes
// the last good result for operand A).
`timescale 1ns/1ps

module alu_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_opcode,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic        req_chain,
`endif
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned PTR_AW = PTR_W + 1;
  localparam int unsigned CNT_W  = $clog2(LATENCY + 1);

  localparam logic [OP_W-1:0] OP_CLEAR = 4'b1111;

  // One queued request
  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
`ifdef ALU_SEQ_CHAIN_EN
    logic              chain;
`endif
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  req_t              r_mem [DEPTH];
  logic [PTR_AW-1:0] r_wptr;
  logic [PTR_AW-1:0] r_rptr;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic              w_err_rsp;
  logic              w_capture;
  logic              w_rsp_done;
  req_t              w_wr_entry;
  req_t              w_head;
  logic [DATA_W-1:0] w_issue_a;

`ifdef ALU_SEQ_CHAIN_EN
  logic [DATA_W-1:0] r_last_res;
`endif

  // Opcode legality: 0111 and 1100-1110 are unassigned
  function automatic logic f_legal(input logic [OP_W-1:0] op);
    logic ok;
    case (op)
      4'b0111, 4'b1100, 4'b1101, 4'b1110: ok = 1'b0;
      default:                            ok = 1'b1;
    endcase
    return ok;
  endfunction

  // FIFO status from registered pointers only
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_push  = req_valid && !w_full;
  assign w_head  = r_mem[r_rptr[PTR_W-1:0]];

  assign req_ready = !w_full;
  assign busy      = (r_state != S_IDLE) || !w_empty;

  // Pack the incoming request
  always_comb begin
    w_wr_entry        = '0;
    w_wr_entry.opcode = req_opcode;
    w_wr_entry.a      = req_a;
    w_wr_entry.b      = req_b;
`ifdef ALU_SEQ_CHAIN_EN
    w_wr_entry.chain  = req_chain;
`endif
  end

  // Operand A source: chained result or the queued operand
`ifdef ALU_SEQ_CHAIN_EN
  assign w_issue_a = w_head.chain ? r_last_res : w_head.a;
`else
  assign w_issue_a = w_head.a;
`endif

  // FIFO storage write (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[PTR_W-1:0]] <= w_wr_entry;
    end
  end

  // FIFO pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_AW'(1);
      end
    end
  end

  // FSM state and latency counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_err_rsp   = 1'b0;
    w_capture   = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (f_legal(w_head.opcode)) begin
            w_issue     = 1'b1;
            w_cnt_nxt   = CNT_W'(LATENCY);
            w_state_nxt = S_WAIT;
          end else begin
            w_err_rsp   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ALU drive registers: change only on issue, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= OP_CLEAR;
      alu_a      <= '0;
      alu_b      <= '0;
    end else if (w_issue) begin
      alu_opcode <= w_head.opcode;
      alu_a      <= w_issue_a;
      alu_b      <= w_head.b;
    end
  end

  // Response registers: load on capture or error, hold until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else if (w_err_rsp) begin
      rsp_valid <= 1'b1;
      rsp_data  <= '0;
      rsp_err   <= 1'b1;
    end else if (w_capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_result;
      rsp_err   <= 1'b0;
    end else if (w_rsp_done) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_SEQ_CHAIN_EN
  // Last good result, source for chained operand A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_res <= '0;
    end else if (w_capture) begin
      r_last_res <= alu_result;
    end
  end
`endif

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Operation sequencer for the 16-bit ALU datapath. Accepts ALU operation requests (opcode, A, B) over a valid/ready handshake and buffers them in a small FIFO. Issues them one at a time to the ALU Breadboard inputs, waits a fixed number of cycles for the accumulator-registered result, then returns that result over a second valid/ready handshake. Sits between any requester (testbench driver, future instruction decoder) and the ALU, replacing free-running stimulus.

## Interface

- DEPTH, 4, request FIFO entries; power of two, ≥2
- LATENCY, 2, clk edges from ALU input update to valid `alu_result`; ≥1
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_opcode  in  4  ALU opcode
- req_a  in  16  operand A
- req_b  in  16  operand B
- req_chain  in  1  use previous result as A (only with ALU_SEQ_CHAIN_EN)
- alu_opcode  out  16→4  drives ALU opcode (4 bits)
- alu_a  out  16  drives ALU a
- alu_b  out  16  drives ALU b
- alu_result  in  16  ALU accumulator output
- rsp_valid  out  1  result held
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  16  captured result
- rsp_err  out  1  illegal opcode flag for this response
- busy  out  1  FSM not IDLE or FIFO non-empty

## Operation

- Legal opcodes: 0000–0110, 1000–1011, 1111 (AND, OR, NOT, XOR, NAND, NOR, XNOR, ADD, SUB, SHR, SHL, CLEAR). Illegal: 0111, 1100–1110.
- Request accepted on a rising edge with req_valid & req_ready; the entry is written to the FIFO. req_ready = !full, computed from registered FIFO state. A pop in the same cycle does not raise req_ready.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head.
    - Legal opcode: register alu_opcode/alu_a/alu_b, load counter = LATENCY, go to WAIT.
    - Illegal opcode: leave alu_* unchanged, set rsp_data = 0, rsp_err = 1, rsp_valid = 1, go to DONE.
  - WAIT: decrement the counter each edge. At the edge where the counter reaches 0, capture alu_result into rsp_data, set rsp_err = 0, rsp_valid = 1, go to DONE.
  - DONE: hold rsp_*. On rsp_valid & rsp_ready, clear rsp_valid and go to IDLE. Next pop occurs no earlier than the following edge.
- alu_* hold the last issued values between operations. The ALU is never driven while in WAIT.
- Responses return strictly in request order, one outstanding ALU operation at a time.
- FIFO pointers are log2(DEPTH)+1 bits wide. Full/empty are taken from the MSB compare; pointers wrap modulo 2·DEPTH.
- Reset (async, any state, including mid-WAIT):
  - FSM goes to IDLE, FIFO empties, counter = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0.
  - alu_opcode = 1111 (CLEAR), alu_a = alu_b = 0.
  - req_ready = 1, busy = 0.
  - Any in-flight operation is discarded with no response.

## Timing

- Accept at edge T, FIFO initially empty, FSM in IDLE:
  - alu_* updated at edge T+1.
  - rsp_valid rises at edge T+1+LATENCY (T+3 with default).
- Illegal opcode accepted at T: rsp_valid with rsp_err rises at edge T+1.
- Back-to-back throughput: one operation per LATENCY+2 cycles when rsp_ready is held high.
- Capacity: DEPTH queued plus one in flight. With rsp_ready low, DEPTH+1 requests are accepted before req_ready stays low.
- rsp_data/rsp_err are stable while rsp_valid = 1 and rsp_ready = 0.

## Configuration

- ALU_SEQ_CHAIN_EN defined:
  - req_chain port exists and is stored per FIFO entry.
  - On issue with chain = 1, alu_a = last non-error captured result (register reset to 0; unchanged by error responses) instead of req_a.
- ALU_SEQ_CHAIN_EN undefined: no req_chain port, no chain register; alu_a always = req_a.

## Test plan

- Reset then ADD (1000), a = 2, b = 3 accepted at T -> alu_opcode = 1000 at T+1; rsp_valid at T+3 with rsp_data = 5, rsp_err = 0.
- SUB a = 2, b = 3 -> rsp_data = 0xFFFF; SHL a = 0x0080 -> 0x0100; SHR a = 0x0008 -> 0x0004; responses arrive in order.
- Opcode 0111 -> rsp_valid at T+1, rsp_err = 1, rsp_data = 0, alu_opcode unchanged.
- rsp_ready held 0, req_valid held 1 -> exactly 5 accepts, then req_ready = 0. Raise rsp_ready -> all 5 responses drain in order, req_ready returns to 1.
- rst_n pulsed low during WAIT -> rsp_valid = 0, alu_opcode = 1111, alu_a = 0, req_ready = 1 immediately; no stale response after release.
- (ALU_SEQ_CHAIN_EN) ADD 2,3 then chained SUB b = 1 -> second issue drives alu_a = 5, rsp_data = 4.
